// File: rtl/sigpulse_pkg.sv
// Shared definitions for the multi-channel pulse generator: state encoding
// and default counter widths.
package sigpulse_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int DEF_REP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/sigpulse_ch.sv
// Single pulse-generator channel: trigger-time shadow registers, a shared
// down-counter for delay/width/gap, and a burst repeat counter.
module sigpulse_ch
    import sigpulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             io_clk,
    input  logic             io_rst,
    input  logic             io_en,
    input  logic             pwm_dis,
    input  logic             io_defaultLevel,
    input  logic [CNT_W-1:0] io_trigDelay,
    input  logic [CNT_W-1:0] io_pulseWidth,
    input  logic [CNT_W-1:0] io_gap,
    input  logic [REP_W-1:0] io_repeat,
    output logic             io_pulseOut,
    output logic             busy,
    output logic             pulse_valid
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_q;
    logic [REP_W-1:0] rep_q;
    logic             lvl_q;
    logic             act_q;
    logic             valid_q;

    // NOTE: every flop here is assigned with <= so all channel state updates
    // together on the edge; blocking writes would leak same-cycle ordering.
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            width_q <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
            lvl_q   <= 1'b0;
            act_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (pwm_dis) begin
                // Abort strobes only if there was a burst to abort.
                valid_q <= (state != ST_IDLE);
                state   <= ST_IDLE;
                act_q   <= 1'b0;
                cnt     <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (io_en) begin
                            width_q <= io_pulseWidth;
                            gap_q   <= (io_gap == '0) ? CNT_ONE : io_gap;
                            rep_q   <= (io_repeat == '0) ? REP_ONE : io_repeat;
                            lvl_q   <= io_defaultLevel;
                            if (io_trigDelay != '0) begin
                                state <= ST_DELAY;
                                cnt   <= io_trigDelay;
                            end else if (io_pulseWidth != '0) begin
                                state <= ST_PULSE;
                                act_q <= 1'b1;
                                cnt   <= io_pulseWidth;
                            end else begin
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (cnt == CNT_ONE) begin
                            if (width_q != '0) begin
                                state <= ST_PULSE;
                                act_q <= 1'b1;
                                cnt   <= width_q;
                            end else begin
                                state   <= ST_IDLE;
                                valid_q <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt == CNT_ONE) begin
                            act_q <= 1'b0;
                            if (rep_q == REP_ONE) begin
                                state   <= ST_IDLE;
                                valid_q <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                                cnt   <= gap_q;
                                rep_q <= rep_q - REP_ONE;
                            end
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    ST_GAP: begin
                        if (cnt == CNT_ONE) begin
                            state <= ST_PULSE;
                            act_q <= 1'b1;
                            cnt   <= width_q;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: the flops clear to 0 on reset; the idle level comes from the live
    // input through this select, so the pin is correct even while in reset.
    assign busy        = (state != ST_IDLE);
    assign io_pulseOut = act_q ? ~lvl_q : (busy ? lvl_q : io_defaultLevel);
    assign pulse_valid = valid_q;

endmodule

// File: rtl/sigpulse_mc.sv
// Multi-channel pulse generator: NUM_CH independent sigpulse_ch instances
// with per-channel slices of the packed configuration vectors.
module sigpulse_mc
    import sigpulse_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int REP_W  = DEF_REP_W
) (
    input  logic                    io_clk,
    input  logic                    io_rst,
    input  logic [NUM_CH-1:0]       io_en,
    input  logic [NUM_CH-1:0]       pwm_dis,
    input  logic [NUM_CH-1:0]       io_defaultLevel,
    input  logic [NUM_CH*CNT_W-1:0] io_trigDelay,
    input  logic [NUM_CH*CNT_W-1:0] io_pulseWidth,
    input  logic [NUM_CH*CNT_W-1:0] io_gap,
    input  logic [NUM_CH*REP_W-1:0] io_repeat,
    output logic [NUM_CH-1:0]       io_pulseOut,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       pulse_valid
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sigpulse_ch #(
            .CNT_W(CNT_W),
            .REP_W(REP_W)
        ) u_ch (
            .io_clk         (io_clk),
            .io_rst         (io_rst),
            .io_en          (io_en[i]),
            .pwm_dis        (pwm_dis[i]),
            .io_defaultLevel(io_defaultLevel[i]),
            .io_trigDelay   (io_trigDelay[i*CNT_W +: CNT_W]),
            .io_pulseWidth  (io_pulseWidth[i*CNT_W +: CNT_W]),
            .io_gap         (io_gap[i*CNT_W +: CNT_W]),
            .io_repeat      (io_repeat[i*REP_W +: REP_W]),
            .io_pulseOut    (io_pulseOut[i]),
            .busy           (busy[i]),
            .pulse_valid    (pulse_valid[i])
        );
    end

endmodule

// File: doc/sigpulse_mc.md
Name: sigpulse_mc

Overview:
Multi-channel successor to the single-channel pulse generator. Each of NUM_CH independent channels produces, per trigger, a burst of pulses with these settings, all latched at trigger time:
- programmable trigger delay
- pulse width
- inter-pulse gap
- repeat count
- idle polarity
Each channel has a busy flag and a one-cycle completion strobe. The block sits between the register/RAM configuration space and the output pins of the trigger subsystem.

Parameters:
- NUM_CH, 4: number of independent channels.
- CNT_W, 32: width of the delay, width and gap counters, in clock cycles.
- REP_W, 16: width of the repeat count.

Ports:
- io_clk  in  1  system clock; all timing is in io_clk cycles.
- io_rst  in  1  asynchronous, active-high reset.
- io_en  in  NUM_CH  per-channel trigger (level sampled on clock edge).
- pwm_dis  in  NUM_CH  per-channel abort/disable.
- io_defaultLevel  in  NUM_CH  per-channel idle output level; active level is its inverse.
- io_trigDelay  in  NUM_CH*CNT_W  per-channel delay. Channel i occupies bits [i*CNT_W +: CNT_W]; same packing for all vector ports.
- io_pulseWidth  in  NUM_CH*CNT_W  per-channel pulse width (active cycles).
- io_gap  in  NUM_CH*CNT_W  per-channel inactive cycles between pulses of a burst.
- io_repeat  in  NUM_CH*REP_W  per-channel pulses per burst.
- io_pulseOut  out  NUM_CH  registered pulse outputs.
- busy  out  NUM_CH  channel not IDLE.
- pulse_valid  out  NUM_CH  one-cycle completion/abort strobe.

Behaviour:
- Reset (async, any time, including mid-burst):
  - all channels go to IDLE; counters cleared.
  - busy=0, pulse_valid=0.
  - io_pulseOut = io_defaultLevel. The reset path drives the flop to the live io_defaultLevel through combinational output select on state; the flops themselves reset to 0.
- Per-channel FSM states: IDLE, DELAY, PULSE, GAP.
- io_pulseOut = ~io_defaultLevel exactly in PULSE cycles, otherwise io_defaultLevel. It is driven from registered state, so no glitches.
- busy = (state != IDLE).
- Trigger:
  - io_en=1 in IDLE at edge t latches delay, width, gap, repeat and defaultLevel into shadow registers.
  - Later changes to the inputs have no effect until the next trigger.
  - io_en while busy is ignored; no retrigger or extension.
- Edge t+1 onward:
  - DELAY for D cycles (D = latched delay). D=0 skips DELAY entirely.
  - First active cycle = t+1+D.
- PULSE:
  - lasts W cycles.
  - W=0 means no pulse: the burst ends immediately after DELAY and the completion strobe fires.
- After each pulse, with remaining repeats > 0:
  - GAP for max(G,1) cycles, then PULSE again.
  - Pulses of a burst are never merged.
- Repeat count R: R=0 is treated as R=1. Exactly R pulses per burst.
- Completion:
  - the final PULSE/DELAY exit goes to IDLE.
  - pulse_valid=1 for exactly the first IDLE cycle.
  - busy falls in the same cycle.
  - A new io_en in that same cycle is accepted.
- pwm_dis priority: highest after reset.
  - In any non-IDLE state: go to IDLE next edge, output returns to idle level that edge, pulse_valid strobes once.
  - In IDLE: no strobe, and io_en in the same cycle is ignored.
  - Held high: channel stays IDLE.
- Counters decrement to terminal value 1, then transition. No wrap-around is possible.
- Max values (all ones) are legal. Arithmetic is unsigned, CNT_W/REP_W wide.
- Channels are fully independent. Simultaneous triggers on all channels are legal.

Decomposition:
- Shared package sigpulse_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_DELAY=2'd1, ST_PULSE=2'd2, ST_GAP=2'd3.
  - default CNT_W/REP_W.
- One sub-module, sigpulse_ch: single-channel FSM, shadow registers and counters.
- sigpulse_mc is a generate loop of NUM_CH sigpulse_ch instances with vector slicing.

Test Plan:
- Ch0, defaultLevel=0, D=3, W=5, R=1, io_en at edge t:
  - out high on cycles t+4..t+8.
  - pulse_valid high at t+9 only.
  - busy high t+1..t+8.
- Ch1, defaultLevel=1, D=0, W=2, G=3, R=3:
  - out low t+1..2, high 3 cycles, low 2, high 3, low 2, then high.
  - exactly 3 pulses; one pulse_valid.
- Ch2, G=0, W=1, R=2:
  - two 1-cycle pulses separated by exactly 1 idle-level cycle.
  - W=0, D=4: no active cycle; pulse_valid at t+5.
- Ch0 mid-PULSE pwm_dis pulse:
  - out idle next cycle, pulse_valid one cycle, busy 0.
  - io_en while busy is ignored: the burst length is unchanged.
- io_rst asserted asynchronously mid-GAP on all channels:
  - outputs immediately at idle level; busy=0; no pulse_valid.
  - the next trigger runs normally.
- All 4 channels triggered simultaneously with different D/W, plus retrigger in the pulse_valid cycle:
  - independent correct timing per channel.
  - the retriggered burst starts the following cycle.
